parser_rule_readback: RTL
=========================

// Module: parser_rule_readback
// PURPOSE
//  Read-side responder for the per-layer rule configuration bus; the write side is Rule_Conf.
//  Snoops every rule write into a shadow RAM. Serves single-word reads with fixed 2-cycle latency.
//  Supports a bulk dump of the whole rule table, one word per beat.
//  Instanced once per parser layer; its outputs drive that layer's o_rule_rdata_valid/o_rule_rdata.
// PARAMETERS
//  LAYER_ID        0    layer index; used only by sim messages
//  RULE_NUM        8    rules per layer (power of 2)
//  WORDS_PER_RULE  16   32-bit config words per rule (power of 2); last word = commit word
//  Derived: WORD_W=$clog2(WORDS_PER_RULE), RULE_W=$clog2(RULE_NUM), DEPTH=RULE_NUM*WORDS_PER_RULE
// PORTS
//  i_clk               in   1         clock
//  i_rst               in   1         synchronous reset, active-high
//  i_rule_wren         in   1         config write strobe (same bus as Rule_Conf)
//  i_rule_rden         in   1         single-word read request
//  i_rule_addr         in   32        {0.., rule_id[RULE_W], word_idx[WORD_W]}
//  i_rule_wdata        in   32        write data
//  o_rule_rd_ready     out  1         read request accepted this cycle when high
//  o_rule_rdata_valid  out  1         read/dump data beat valid
//  o_rule_rdata        out  32        read/dump data
//  o_rule_rd_err       out  1         beat flag: out-of-range addr (or parity error, see CONFIGURATION)
//  i_dump_req          in   1         start full-table dump (pulse)
//  o_dump_busy         out  1         dump in progress, including drain
//  o_dump_last         out  1         marks the final dump beat (word DEPTH-1)
//  o_rule_valid        out  RULE_NUM  per-rule committed flag
// BEHAVIOUR
//  Reset: all outputs 0 except o_rule_rd_ready=1; FSM=IDLE; o_rule_valid=0. Shadow RAM is not cleared.
//  Addr decode: if bits above WORD_W+RULE_W are nonzero, the address is out of range.
//  Writes: always accepted, in every FSM state. In-range writes update RAM[rule_id*WORDS_PER_RULE+word_idx].
//   Out-of-range writes are dropped.
//  Commit: a write to word_idx=WORDS_PER_RULE-1 sets o_rule_valid[rule_id]=wdata[0] on the next cycle.
//  Read accept: i_rule_rden && o_rule_rd_ready. Data appears exactly 2 cycles later (o_rule_rdata_valid=1, 1 beat).
//  Read data: RAM word if the rule is valid, else 32'h0 (masks stale contents after reset).
//   Out-of-range: 32'h0 with o_rule_rd_err=1.
//  Same-cycle write+read, same address: the read returns the new wdata (write-first forwarding).
//   The valid mask uses the post-write o_rule_valid.
//  Write to an address with a read already in flight: the in-flight read keeps the value sampled at accept.
//  Back-to-back reads: one accepted per cycle, fully pipelined, no bubbles.
//  FSM IDLE -> DUMP: i_dump_req in IDLE. Ready drops the same cycle, so no read is accepted with a req.
//   Reads in flight still complete in order before the first dump beat.
//  DUMP: issues internal reads for addr 0..DEPTH-1 at 1/cycle, with the same masking and forwarding as single reads.
//   o_dump_last is asserted with the beat for DEPTH-1. DUMP -> DRAIN after the DEPTH-1 issue.
//  DRAIN: wait 2 cycles for the pipeline to empty, then -> IDLE.
//  o_rule_rd_ready=0 in DUMP and DRAIN; o_dump_busy=1 in DUMP and DRAIN.
//  i_dump_req outside IDLE is ignored.
//  i_rule_rden while not ready is dropped, not queued; the requester retries.
//  Reset mid-dump or mid-read: pipeline flushed the next cycle; no further valid beats; FSM=IDLE.
// CONFIGURATION
//  RULE_RD_PARITY_EN defined: the RAM stores 1 even-parity bit per word, computed on write.
//   Read checks parity; a mismatch sets o_rule_rd_err on that beat, with data returned unmodified.
//   Masked (invalid-rule) reads never flag.
//  RULE_RD_PARITY_EN undefined: no parity storage; o_rule_rd_err reflects only out-of-range.
// TESTING
//  1 Write words 0..15 of rule 3, word 15=32'h1, then read addr 0x35 -> data = written word 5, 2 cycles later.
//    Also o_rule_valid=8'h08.
//  2 After reset, read rule 3 word 5 without committing -> 32'h0, rd_err=0.
//    Read addr 32'h0001_0000 -> 32'h0, rd_err=1.
//  3 Same cycle: write 0x12=32'hA5A5_0001 and read 0x12 (rule 1 committed) -> 32'hA5A5_0001.
//    Then write 0x12 one cycle after a read of 0x12 -> the read returns the old value.
//  4 Read 0x00,0x01,0x02 back-to-back -> 3 consecutive valid beats, in order, starting cycle+2.
//  5 Dump, defaults, rules 0 and 7 committed -> 128 consecutive beats addr-ordered; rules 1..6 read 0.
//    o_dump_last on beat 128; rd_ready=0 throughout; a rden during the dump gets no response.
//  6 Assert i_rst at dump beat 40 -> no valid beat after the reset cycle; rd_ready=1; o_rule_valid=0.
//    With RULE_RD_PARITY_EN: force a RAM bit flip, read it -> rd_err=1.

Source files
------------

// File: rtl/parser_rule_readback.sv
// -----------------------------------------------------------------------------
// parser_rule_readback
//
// Read-side responder for one parser layer's rule configuration bus. Every
// rule write on the shared bus is copied into a shadow RAM. The block serves
// single-word reads with a fixed two-cycle latency. It also streams the whole
// rule table out, one word per beat, when a dump is requested.
//
// Optional feature macro: RULE_RD_PARITY_EN
//   When defined, each shadow word carries one even-parity bit. The bit is
//   computed on write and checked on read. A mismatch raises o_rule_rd_err on
//   that beat and leaves the data unchanged.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_rule_wren         config write strobe (always accepted)
//   i_rule_rden         single-word read request
//   i_rule_addr         {0.., rule_id, word_idx}; shared by writes and reads
//   i_rule_wdata        write data
//   o_rule_rd_ready     read request accepted this cycle when high
//   o_rule_rdata_valid  one data beat (single read or dump)
//   o_rule_rdata        beat data; 0 for uncommitted rules or bad addresses
//   o_rule_rd_err       beat flag: out-of-range address (or parity error)
//   i_dump_req          start a full-table dump (honoured only in IDLE)
//   o_dump_busy         dump or its pipeline drain is in progress
//   o_dump_last         marks the beat carrying word DEPTH-1
//   o_rule_valid        per-rule committed flags
//
// Read handshake: a request is accepted in any cycle where i_rule_rden and
// o_rule_rd_ready are both high. Exactly one beat follows, two clock edges
// later. A request made while ready is low is dropped, not queued.
// -----------------------------------------------------------------------------
module parser_rule_readback #(
    parameter int LAYER_ID       = 0,
    parameter int RULE_NUM       = 8,
    parameter int WORDS_PER_RULE = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_rule_wren,
    input  logic                i_rule_rden,
    input  logic [31:0]         i_rule_addr,
    input  logic [31:0]         i_rule_wdata,
    output logic                o_rule_rd_ready,
    output logic                o_rule_rdata_valid,
    output logic [31:0]         o_rule_rdata,
    output logic                o_rule_rd_err,
    input  logic                i_dump_req,
    output logic                o_dump_busy,
    output logic                o_dump_last,
    output logic [RULE_NUM-1:0] o_rule_valid
);
    localparam int WORD_W = $clog2(WORDS_PER_RULE);
    localparam int RULE_W = $clog2(RULE_NUM);
    localparam int AW     = WORD_W + RULE_W;
    localparam int DEPTH  = RULE_NUM * WORDS_PER_RULE;
    localparam int unused_layer_id = LAYER_ID;

    typedef enum logic [1:0] {ST_IDLE, ST_DUMP, ST_DRAIN} state_t;

    state_t              r_state;
    logic [AW-1:0]       r_dump_addr;
    logic                r_drain_cnt;
    logic [RULE_NUM-1:0] r_rule_valid;
    logic [31:0]         r_mem [DEPTH];

    // Pipeline stage 1 holds the value sampled at accept. Later writes to the
    // same word therefore do not affect a read that is already in flight.
    logic        r_s1_valid, r_s1_err, r_s1_last;
    logic [31:0] r_s1_data;
    logic        r_out_valid, r_out_err, r_out_last;
    logic [31:0] r_out_data;

    // Shared address decode
    logic              w_addr_ok;
    logic [AW-1:0]     w_addr_idx;
    logic              w_wr_en, w_wr_commit;
    logic [RULE_W-1:0] w_wr_rule;

    assign w_addr_ok   = (i_rule_addr[31:AW] == '0);
    assign w_addr_idx  = i_rule_addr[AW-1:0];
    assign w_wr_en     = i_rule_wren && w_addr_ok;
    assign w_wr_rule   = w_addr_idx[AW-1:WORD_W];
    assign w_wr_commit = w_wr_en && (w_addr_idx[WORD_W-1:0] == WORD_W'(WORDS_PER_RULE - 1));

    // Read issue: either an accepted single read or the dump walker
    logic              w_dumping, w_rd_issue, w_rd_oor, w_fwd, w_rule_vld;
    logic              w_par_err, w_rd_err, w_rd_last;
    logic [AW-1:0]     w_rd_idx;
    logic [RULE_W-1:0] w_rd_rule;
    logic [31:0]       w_ram_word, w_word, w_rd_data;

    assign o_rule_rd_ready = (r_state == ST_IDLE) && !i_dump_req;
    assign w_dumping  = (r_state == ST_DUMP);
    assign w_rd_issue = w_dumping || (i_rule_rden && o_rule_rd_ready);
    assign w_rd_idx   = w_dumping ? r_dump_addr : w_addr_idx;
    assign w_rd_oor   = !w_dumping && !w_addr_ok;
    assign w_rd_rule  = w_rd_idx[AW-1:WORD_W];
    assign w_ram_word = r_mem[w_rd_idx];

    // Write-first: a same-cycle write to the read word is forwarded. A
    // same-cycle commit of the read rule decides the mask.
    assign w_fwd      = w_wr_en && (w_rd_idx == w_addr_idx);
    assign w_rule_vld = (w_wr_commit && (w_wr_rule == w_rd_rule)) ? i_rule_wdata[0]
                                                                  : r_rule_valid[w_rd_rule];
    assign w_word     = w_fwd ? i_rule_wdata : w_ram_word;
    assign w_rd_data  = (!w_rd_oor && w_rule_vld) ? w_word : 32'h0;
    assign w_rd_last  = w_dumping && (r_dump_addr == AW'(DEPTH - 1));

`ifdef RULE_RD_PARITY_EN
    logic r_par [DEPTH];

    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_par[w_addr_idx] <= ^i_rule_wdata;
        end
    end

    // Forwarded data never came from the array, so it is never checked.
    // Masked reads are never flagged either.
    assign w_par_err = !w_rd_oor && w_rule_vld && !w_fwd &&
                       ((^w_ram_word) != r_par[w_rd_idx]);
`else
    assign w_par_err = 1'b0;
`endif

    assign w_rd_err = w_rd_oor || w_par_err;

    // Shadow RAM: never reset; stale words are hidden by the commit mask
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[w_addr_idx] <= i_rule_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_dump_addr  <= '0;
            r_drain_cnt  <= 1'b0;
            r_rule_valid <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_err     <= 1'b0;
            r_s1_last    <= 1'b0;
            r_s1_data    <= '0;
            r_out_valid  <= 1'b0;
            r_out_err    <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_data   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_dump_req) begin
                        r_state     <= ST_DUMP;
                        r_dump_addr <= '0;
                    end
                end
                ST_DUMP: begin
                    r_dump_addr <= r_dump_addr + 1'b1;
                    if (w_rd_last) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // Two cycles let the last issued word reach the output
                    if (r_drain_cnt) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_drain_cnt <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_wr_commit) begin
                r_rule_valid[w_wr_rule] <= i_rule_wdata[0];
            end

            r_s1_valid  <= w_rd_issue;
            r_s1_data   <= w_rd_issue ? w_rd_data : 32'h0;
            r_s1_err    <= w_rd_issue && w_rd_err;
            r_s1_last   <= w_rd_issue && w_rd_last;

            r_out_valid <= r_s1_valid;
            r_out_data  <= r_s1_data;
            r_out_err   <= r_s1_err;
            r_out_last  <= r_s1_last;
        end
    end

    assign o_rule_rdata_valid = r_out_valid;
    assign o_rule_rdata       = r_out_data;
    assign o_rule_rd_err      = r_out_err;
    assign o_dump_last        = r_out_last;
    assign o_dump_busy        = (r_state != ST_IDLE);
    assign o_rule_valid       = r_rule_valid;

endmodule
